// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, constants and helpers for the dmem load/store unit
//
// Purpose: FSM state encoding, RV32I load/store funct3 codes, memory
// direction codes and the access-size helper used by dmem_lsu and
// lsu_lane_align.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    DONE = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Access size in bytes (1, 2 or 4); illegal codes fall back to 4 and
  // are rejected before any memory access is made.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      default:     size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane merge for stores and extract/extend for loads
//
// Purpose: purely combinational lane steering over a two-word window
// {word1, word0}, little-endian, lane k = bits [8k+7:8k].
// Ports:
//   off_i     byte offset of the access inside word0
//   size_i    access size in bytes (1, 2 or 4)
//   funct3_i  RV32I funct3, selects load extension
//   wdata_i   right-justified store data
//   word0_i   current contents of the first word
//   word1_i   current contents of the second (next) word
//   merged0_o word0 with the store bytes that fall into it
//   merged1_o word1 with the store bytes that spill past word0
//   load_o    extracted and extended load data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      off_i,
  input  logic [2:0]      size_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] word0_i,
  input  logic [XLEN-1:0] word1_i,
  output logic [XLEN-1:0] merged0_o,
  output logic [XLEN-1:0] merged1_o,
  output logic [XLEN-1:0] load_o
);

  logic [3:0]        size_mask;
  logic [7:0]        wide_mask;
  logic [2*XLEN-1:0] wide_data;
  logic [2*XLEN-1:0] raw;

  always_comb begin
    case (size_i)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase

    // Lanes 0-3 of the window belong to word0, lanes 4-7 to word1.
    wide_mask = {4'b0000, size_mask} << off_i;
    wide_data = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};

    merged0_o = word0_i;
    merged1_o = word1_i;
    for (int k = 0; k < 4; k++) begin
      if (wide_mask[k])     merged0_o[8*k +: 8] = wide_data[8*k +: 8];
      if (wide_mask[k + 4]) merged1_o[8*k +: 8] = wide_data[XLEN + 8*k +: 8];
    end

    raw = {word1_i, word0_i} >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    load_o = {{24{raw[7]}}, raw[7:0]};
      F3_H:    load_o = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   load_o = {24'h000000, raw[7:0]};
      F3_HU:   load_o = {16'h0000, raw[15:0]};
      default: load_o = raw[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit in front of a word-addressed data memory
//
// Purpose: turns byte-addressed loads/stores into whole-word reads/writes,
// does read-modify-write for sub-word stores and splits accesses that cross
// a word boundary into two word accesses (word index wraps mod 2^30).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/req_funct3          store flag and RV32I funct3
//   req_addr/req_wdata         byte address, right-justified store data
//   resp_valid/rdata/err       one-cycle completion pulse with load data
//   mem_addr/mem_rw/mem_wdata  registered word index, direction, write word
//   mem_din/mem_dout           size selects, tied to full-word
//   mem_rdata                  combinational read data
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [DATA_SIZE-1:0]    resp_rdata,
  output logic                    resp_err,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic                    mem_rw,
  output logic [1:0]              mem_din,
  output logic [2:0]              mem_dout,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  input  logic [DATA_SIZE-1:0]    mem_rdata
);

  localparam int WW = ADDRESS_SIZE - 2;

  lsu_state_e               state_q;
  logic                     req_ready_q;
  logic                     resp_valid_q;
  logic                     resp_err_q;
  logic [DATA_SIZE-1:0]     resp_rdata_q;
  logic [ADDRESS_SIZE-1:0]  mem_addr_q;
  logic                     mem_rw_q;
  logic [DATA_SIZE-1:0]     mem_wdata_q;

  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [1:0]               off_q;
  logic [2:0]               size_q;
  logic                     span_q;
  logic [WW-1:0]            w0_q;
  logic [WW-1:0]            w1_q;
  logic [DATA_SIZE-1:0]     wdata_q;
  logic [DATA_SIZE-1:0]     buf0_q;
  logic [DATA_SIZE-1:0]     buf1_q;

  logic [WW-1:0]            req_w0;
  logic [1:0]               req_off;
  logic [2:0]               req_size;
  logic                     req_legal;
  logic [DATA_SIZE-1:0]     word0_src;
  logic [DATA_SIZE-1:0]     word1_src;
  logic [DATA_SIZE-1:0]     merged0;
  logic [DATA_SIZE-1:0]     merged1;
  logic [DATA_SIZE-1:0]     load_data;

  assign req_w0   = req_addr[ADDRESS_SIZE-1:2];
  assign req_off  = req_addr[1:0];
  assign req_size = size_of(req_funct3);
  assign req_legal = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W})
                            : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

  // The word being read this cycle is still on mem_rdata; it lands in the
  // buffer only at the edge that ends RD0/RD1, so steer it in directly.
  assign word0_src = (state_q == RD0) ? mem_rdata : buf0_q;
  assign word1_src = (state_q == RD1) ? mem_rdata : buf1_q;

  lsu_lane_align u_align (
    .off_i     (off_q),
    .size_i    (size_q),
    .funct3_i  (funct3_q),
    .wdata_i   (wdata_q),
    .word0_i   (word0_src),
    .word1_i   (word1_src),
    .merged0_o (merged0),
    .merged1_o (merged1),
    .load_o    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_rw_q     <= MEM_READ;
      mem_wdata_q  <= '0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      size_q       <= 3'd4;
      span_q       <= 1'b0;
      w0_q         <= '0;
      w1_q         <= '0;
      wdata_q      <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      // Response and write strobe are single-cycle unless re-armed below.
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_rw_q     <= MEM_READ;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= req_off;
            size_q      <= req_size;
            span_q      <= ({1'b0, req_off} + req_size) > 3'd4;
            w0_q        <= req_w0;
            w1_q        <= req_w0 + 1'b1;
            wdata_q     <= req_wdata;
            if (!req_legal) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && req_funct3 == F3_W && req_off == 2'b00) begin
              state_q     <= WR0;
              mem_addr_q  <= {2'b00, req_w0};
              mem_rw_q    <= MEM_WRITE;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= RD0;
              mem_addr_q <= {2'b00, req_w0};
            end
          end
        end

        RD0: begin
          buf0_q <= mem_rdata;
          if (span_q) begin
            state_q    <= RD1;
            mem_addr_q <= {2'b00, w1_q};
          end else if (!we_q) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
          end else begin
            state_q     <= WR0;
            mem_rw_q    <= MEM_WRITE;
            mem_wdata_q <= merged0;
          end
        end

        RD1: begin
          buf1_q <= mem_rdata;
          if (!we_q) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
          end else begin
            state_q     <= WR0;
            mem_addr_q  <= {2'b00, w0_q};
            mem_rw_q    <= MEM_WRITE;
            mem_wdata_q <= merged0;
          end
        end

        WR0: begin
          if (span_q) begin
            state_q     <= WR1;
            mem_addr_q  <= {2'b00, w1_q};
            mem_rw_q    <= MEM_WRITE;
            mem_wdata_q <= merged1;
          end else begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
          end
        end

        WR1: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
        end

        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rw     = mem_rw_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_din    = 2'b00;
  assign mem_dout   = 3'b000;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - scoreboard bench for dmem_lsu with a falling-edge-write memory model
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [1:0]  mem_din;
  logic [2:0]  mem_dout;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_lsu #(.DATA_SIZE(32), .ADDRESS_SIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rw     (mem_rw),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_n;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [31:0] trace[$];
  logic [31:0] exp_tr[4];
  int          wr_cnt = 0;
  int          edge_cnt = 0;
  bit          trace_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    mem[a] = d;
    wr_cnt++;
  endtask

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory: combinational read, write on the falling edge mid-cycle.
  always @(negedge clk) begin
    if (mem_rw === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
      wr_cnt++;
    end
  end

  always @(mem_addr or wr_cnt) mem_rdata = peek(mem_addr);

  always @(posedge clk) edge_cnt++;

  // Monitor: pops the scoreboard on every response, traces busy-cycle addresses.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with empty scoreboard", resp_rdata, resp_err);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_latency", edge_cnt, e.edge_n);
      end
    end
    if (trace_en && rst_n && !req_ready && !resp_valid) trace.push_back(mem_addr);
  end

  // lat = cycles from accept cycle to the resp_valid cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input bit expect_resp);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    if (expect_resp) begin
      e.rdata  = exp_rdata;
      e.err    = exp_err;
      e.edge_n = edge_cnt + lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'b0, (exp_q.size() == 0 && req_ready)}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    exp_tr[0] = 32'h3FFFFFFF;
    exp_tr[1] = 32'h00000000;
    exp_tr[2] = 32'h3FFFFFFF;
    exp_tr[3] = 32'h00000000;
    poke(32'h10, 32'h8899AABB);
    poke(32'h11, 32'h11223344);

    @(posedge clk);
    #2;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_rw", {31'b0, mem_rw}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("mem_din_tie", {30'b0, mem_din}, 32'h0);
    chk("mem_dout_tie", {29'b0, mem_dout}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads: we, f3, addr, wdata, expected rdata, err, latency
    issue(1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b100, 32'h41, 32'h0, 32'h000000AA, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h43, 32'h0, 32'h22334488, 1'b0, 3, 1'b1);

    // Sub-word store with read-modify-write
    wait_idle();
    wlog_a.delete();
    wlog_d.delete();
    issue(1'b1, 3'b000, 32'h42, 32'h000000CC, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    chk("sb_wr_count", wlog_a.size(), 32'd1);
    chk("sb_wdata", (wlog_d.size() > 0) ? wlog_d[0] : 32'hx, 32'h88CCAABB);
    chk("sb_word10", peek(32'h10), 32'h88CCAABB);

    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h88CCAABB, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF88CC, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b101, 32'h43, 32'h0, 32'h00004488, 1'b0, 3, 1'b1);
    issue(1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h44, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b000, 32'h47, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b1);

    // Illegal funct3: immediate error, no memory traffic, mem_addr held
    wait_idle();
    wlog_a.delete();
    wlog_d.delete();
    trace.delete();
    trace_en = 1'b1;
    issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    trace_en = 1'b0;
    chk("illegal_writes", wlog_a.size(), 32'd0);
    chk("illegal_busy_cycles", trace.size(), 32'd0);
    chk("illegal_addr_hold", mem_addr, 32'h11);

    // Wrapping halfword store across word 0x3FFFFFFF / 0
    poke(32'h3FFFFFFF, 32'h01020304);
    poke(32'h00000000, 32'h05060708);
    wlog_a.delete();
    wlog_d.delete();
    trace.delete();
    trace_en = 1'b1;
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 1'b0, 5, 1'b1);
    wait_idle();
    trace_en = 1'b0;
    chk("sh_trace_len", trace.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("sh_addr_seq", (i < trace.size()) ? trace[i] : 32'hx, exp_tr[i]);
    chk("sh_wr_count", wlog_a.size(), 32'd2);
    chk("sh_word_hi", peek(32'h3FFFFFFF), 32'hEF020304);
    chk("sh_word_0", peek(32'h0), 32'h050607BE);

    // Same store, reset asserted during WR1
    poke(32'h3FFFFFFF, 32'h01020304);
    poke(32'h00000000, 32'h05060708);
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 1'b0, 5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("wr1_mem_rw", {31'b0, mem_rw}, 32'h1);
    chk("wr1_mem_addr", mem_addr, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_rw", {31'b0, mem_rw}, 32'h0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_word_hi", peek(32'h3FFFFFFF), 32'hEF020304);
    chk("midrst_word_0", peek(32'h0), 32'h05060708);
    rst_n = 1'b1;

    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h88CCAABB, 1'b0, 2, 1'b1);
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
